// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte valid/ready handshake from the UART receiver into the receive buffer
//   uart_rx_data      received byte, driven by the receiver
//   uart_rx_data_vld  byte valid, held by the receiver until acknowledged
//   uart_rx_data_rdy  one-cycle acknowledge pulse from the buffer
interface uart_rx_fifo_if;
    logic [7:0] uart_rx_data;
    logic       uart_rx_data_vld;
    logic       uart_rx_data_rdy;
    modport master (output uart_rx_data, uart_rx_data_vld, input uart_rx_data_rdy);
    modport slave  (input uart_rx_data, uart_rx_data_vld, output uart_rx_data_rdy);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH-entry first-word-fall-through receive buffer behind the UART receiver
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   rx                  receiver byte handshake (slave side)
//   fifo_rd_i           pop head entry, fifo_flush_i discards all contents
//   fifo_thr_i          occupancy threshold for fifo_irq_o, 0 disables
//   fifo_stall_clr_i    clears the sticky fifo_stall_o
//   fifo_data_o         head byte (0 when empty), fifo_empty_o/fifo_full_o/fifo_cnt_o occupancy
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    uart_rx_fifo_if.slave rx,
    input  logic          fifo_rd_i,
    input  logic          fifo_flush_i,
    input  logic [AW:0]   fifo_thr_i,
    input  logic          fifo_stall_clr_i,
    output logic [7:0]    fifo_data_o,
    output logic          fifo_empty_o,
    output logic          fifo_full_o,
    output logic [AW:0]   fifo_cnt_o,
    output logic          fifo_irq_o,
    output logic          fifo_stall_o
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          rdy, stall, wr_en, rd_en;

    // The ~rdy term blocks the second write while the receiver still shows valid in the ack cycle.
    assign wr_en = rx.uart_rx_data_vld & ~rdy & ~fifo_full_o & ~fifo_flush_i;
    assign rd_en = fifo_rd_i & ~fifo_empty_o & ~fifo_flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rdy    <= 1'b0;
            stall  <= 1'b0;
        end else begin
            rdy    <= wr_en;
            wr_ptr <= fifo_flush_i ? '0 : wr_ptr + AW'(wr_en);
            rd_ptr <= fifo_flush_i ? '0 : rd_ptr + AW'(rd_en);
            cnt    <= fifo_flush_i ? '0 : cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
            stall  <= (rx.uart_rx_data_vld & fifo_full_o) | (stall & ~fifo_stall_clr_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= rx.uart_rx_data;
    end

    assign rx.uart_rx_data_rdy = rdy;
    assign fifo_empty_o = cnt == '0;
    assign fifo_full_o  = cnt == (AW+1)'(DEPTH);
    assign fifo_cnt_o   = cnt;
    assign fifo_irq_o   = (fifo_thr_i != '0) && (cnt >= fifo_thr_i);
    assign fifo_stall_o = stall;
    assign fifo_data_o  = fifo_empty_o ? 8'h00 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner sequences and random traffic against a queue model
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd = 1'b0, fifo_flush = 1'b0, fifo_stall_clr = 1'b0;
    logic [AW:0]   fifo_thr = '0;
    logic [7:0]    fifo_data;
    logic          fifo_empty, fifo_full, fifo_irq, fifo_stall;
    logic [AW:0]   fifo_cnt;

    int            n_assert = 0, n_fail = 0;
    byte unsigned  q[$];
    bit            m_rdy = 1'b0, m_stall = 1'b0;

    uart_rx_fifo_if rx_if();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .rx              (rx_if),
        .fifo_rd_i       (fifo_rd),
        .fifo_flush_i    (fifo_flush),
        .fifo_thr_i      (fifo_thr),
        .fifo_stall_clr_i(fifo_stall_clr),
        .fifo_data_o     (fifo_data),
        .fifo_empty_o    (fifo_empty),
        .fifo_full_o     (fifo_full),
        .fifo_cnt_o      (fifo_cnt),
        .fifo_irq_o      (fifo_irq),
        .fifo_stall_o    (fifo_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Buffer as a byte queue: acceptance rules use the occupancy at the start of the cycle.
    task automatic model_tick();
        int n = q.size();
        bit wr = rx_if.uart_rx_data_vld && !m_rdy && n != DEPTH && !fifo_flush;
        bit rd = fifo_rd && n != 0 && !fifo_flush;
        if (!rst_n) begin
            q.delete();
            m_rdy = 1'b0;
            m_stall = 1'b0;
        end else begin
            m_stall = (rx_if.uart_rx_data_vld && n == DEPTH) || (m_stall && !fifo_stall_clr);
            if (fifo_flush) q.delete();
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(rx_if.uart_rx_data);
            m_rdy = wr;
        end
    endtask

    task automatic step();
        int n;
        @(posedge clk);
        model_tick();
        #1;
        n = q.size();
        chk("m_cnt", fifo_cnt, n);
        chk("m_empty", fifo_empty, n == 0);
        chk("m_full", fifo_full, n == DEPTH);
        chk("m_data", fifo_data, n == 0 ? 0 : q[0]);
        chk("m_irq", fifo_irq, fifo_thr != 0 && n >= fifo_thr);
        chk("m_stall", fifo_stall, m_stall);
        chk("m_rdy", rx_if.uart_rx_data_rdy, m_rdy);
    endtask

    // Receiver behaviour: hold valid until ack, keep it through the ack cycle, then drop it.
    task automatic push(input logic [7:0] b);
        bit got = 1'b0;
        rx_if.uart_rx_data = b;
        rx_if.uart_rx_data_vld = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = rx_if.uart_rx_data_rdy;
        end
        chk("push_ack", got, 1);
        step();
        rx_if.uart_rx_data_vld = 1'b0;
    endtask

    task automatic pop_exp(input logic [7:0] b);
        chk("pop_data", fifo_data, b);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
    endtask

    typedef struct {
        logic        vld;
        logic [7:0]  din;
        logic        rd;
        logic        rdy;
        logic [AW:0] cnt;
        logic [7:0]  dout;
        logic        empty;
        logic        irq;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 5'd1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h5A, 1'b0, 1'b1, 5'd2, 8'hA5, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd2, 8'hA5, 1'b0, 1'b1};
        vt[4] = '{1'b1, 8'h3C, 1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 8'hA5, 1'b0, 1'b1};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 8'h5A, 1'b0, 1'b1};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 8'h3C, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0};

        rx_if.uart_rx_data = 8'h00;
        rx_if.uart_rx_data_vld = 1'b0;

        // Reset
        step();
        step();
        chk("reset_empty", fifo_empty, 1);
        chk("reset_cnt", fifo_cnt, 0);
        chk("reset_data", fifo_data, 0);
        chk("reset_rdy", rx_if.uart_rx_data_rdy, 0);
        rst_n = 1'b1;

        // Three-byte push/pop vectors, threshold 2
        fifo_thr = 5'd2;
        for (int i = 0; i < 10; i++) begin
            rx_if.uart_rx_data_vld = vt[i].vld;
            rx_if.uart_rx_data = vt[i].din;
            fifo_rd = vt[i].rd;
            step();
            chk($sformatf("vec%0d_rdy", i), rx_if.uart_rx_data_rdy, vt[i].rdy);
            chk($sformatf("vec%0d_cnt", i), fifo_cnt, vt[i].cnt);
            chk($sformatf("vec%0d_data", i), fifo_data, vt[i].dout);
            chk($sformatf("vec%0d_empty", i), fifo_empty, vt[i].empty);
            chk($sformatf("vec%0d_irq", i), fifo_irq, vt[i].irq);
        end
        fifo_rd = 1'b0;
        rx_if.uart_rx_data_vld = 1'b0;

        // Fill to full, back-pressure, pop-while-full and pointer wrap; irq disabled
        fifo_thr = '0;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", fifo_full, 1);
        chk("fill_cnt", fifo_cnt, 16);
        chk("thr0_irq", fifo_irq, 0);
        rx_if.uart_rx_data = 8'hEE;
        rx_if.uart_rx_data_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_rdy", rx_if.uart_rx_data_rdy, 0);
            chk("full_stall", fifo_stall, 1);
        end
        chk("full_head", fifo_data, 8'h00);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        chk("rdfull_cnt", fifo_cnt, 15);
        chk("rdfull_rdy", rx_if.uart_rx_data_rdy, 0);
        step();
        chk("refill_rdy", rx_if.uart_rx_data_rdy, 1);
        chk("refill_cnt", fifo_cnt, 16);
        step();
        rx_if.uart_rx_data_vld = 1'b0;
        for (int i = 1; i < 16; i++) pop_exp(8'(i));
        pop_exp(8'hEE);
        chk("drain_empty", fifo_empty, 1);
        chk("drain_data", fifo_data, 0);
        chk("stall_sticky", fifo_stall, 1);
        fifo_stall_clr = 1'b1;
        step();
        fifo_stall_clr = 1'b0;
        chk("stall_clr", fifo_stall, 0);

        // Read and write together on an empty buffer
        rx_if.uart_rx_data = 8'h42;
        rx_if.uart_rx_data_vld = 1'b1;
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        chk("rdempty_cnt", fifo_cnt, 1);
        chk("rdempty_rdy", rx_if.uart_rx_data_rdy, 1);
        chk("rdempty_data", fifo_data, 8'h42);
        step();
        rx_if.uart_rx_data_vld = 1'b0;

        // Threshold 4
        fifo_thr = 5'd4;
        push(8'h43);
        push(8'h44);
        chk("thr_cnt3", fifo_cnt, 3);
        chk("thr_irq3", fifo_irq, 0);
        push(8'h45);
        chk("thr_irq4", fifo_irq, 1);
        push(8'h46);

        // Flush at cnt 5 with a byte pending
        chk("pre_flush_cnt", fifo_cnt, 5);
        rx_if.uart_rx_data = 8'h77;
        rx_if.uart_rx_data_vld = 1'b1;
        fifo_flush = 1'b1;
        step();
        fifo_flush = 1'b0;
        chk("flush_cnt", fifo_cnt, 0);
        chk("flush_rdy", rx_if.uart_rx_data_rdy, 0);
        step();
        chk("postflush_rdy", rx_if.uart_rx_data_rdy, 1);
        chk("postflush_cnt", fifo_cnt, 1);
        chk("postflush_data", fifo_data, 8'h77);
        step();
        rx_if.uart_rx_data_vld = 1'b0;

        // Stall set and clear together, then reset at cnt 7 with stall set
        for (int i = 0; i < 15; i++) push(8'(8'h80 + i));
        rx_if.uart_rx_data = 8'h99;
        rx_if.uart_rx_data_vld = 1'b1;
        fifo_stall_clr = 1'b1;
        step();
        fifo_stall_clr = 1'b0;
        rx_if.uart_rx_data_vld = 1'b0;
        chk("setclr_stall", fifo_stall, 1);
        pop_exp(8'h77);
        for (int i = 0; i < 8; i++) pop_exp(8'(8'h80 + i));
        chk("prerst_cnt", fifo_cnt, 7);
        chk("prerst_stall", fifo_stall, 1);
        rx_if.uart_rx_data = 8'h55;
        rx_if.uart_rx_data_vld = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_irq", fifo_irq, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_stall", fifo_stall, 0);
        chk("rst_rdy", rx_if.uart_rx_data_rdy, 0);
        rst_n = 1'b1;
        step();
        chk("postrst_rdy", rx_if.uart_rx_data_rdy, 1);
        chk("postrst_data", fifo_data, 8'h55);
        step();
        rx_if.uart_rx_data_vld = 1'b0;

        // Random traffic, alternating drain-heavy and fill-heavy phases
        for (int c = 0; c < 3000; c++) begin
            int rdp = ((c / 500) % 2) != 0 ? 15 : 70;
            if (c % 100 == 0) fifo_thr = 5'($urandom_range(0, DEPTH));
            rst_n = $urandom_range(0, 299) != 0;
            rx_if.uart_rx_data_vld = $urandom_range(0, 99) < 60;
            rx_if.uart_rx_data = 8'($urandom);
            fifo_rd = $urandom_range(0, 99) < rdp;
            fifo_flush = $urandom_range(0, 39) == 0;
            fifo_stall_clr = $urandom_range(0, 15) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
